// File: rtl/cpu_8bit_pkg.sv
// cpu_8bit_pkg: shared widths, opcode and sequencer-state encodings, and the
// default program image loaded into the unified memory on reset.
// Optional feature macro: CPU_8BIT_LOGIC_OPS_EN (enables AND/OR/XOR).
package cpu_8bit_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_LDB = 4'h2,
    OP_STA = 4'h3,
    OP_ADD = 4'h4,
    OP_SUB = 4'h5,
    OP_AND = 4'h6,
    OP_OR  = 4'h7,
    OP_XOR = 4'h8,
    OP_JMP = 4'h9,
    OP_JZ  = 4'hA,
    OP_LDI = 4'hB,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'b00,
    ST_DECODE  = 2'b01,
    ST_EXECUTE = 2'b10,
    ST_HALT    = 2'b11
  } state_t;

  // Built-in program: A=mem[14]; B=mem[15]; A+=B; mem[13]=A; A=mem[15];
  // A-=B; if zero jump to 8; mem[12]=A; halt.
  localparam logic [DATA_W-1:0] DEFAULT_PROG [MEM_DEPTH] = '{
    8'h1E, 8'h2F, 8'h40, 8'h3D, 8'h1F, 8'h50, 8'hA8, 8'h3C,
    8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h05
  };

  // True for opcodes whose ALU result is written back to A and updates zf.
  function automatic logic is_alu_op(input logic [3:0] op);
    logic r;
    r = (op == OP_ADD) || (op == OP_SUB);
`ifdef CPU_8BIT_LOGIC_OPS_EN
    r = r || (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
`endif
    return r;
  endfunction

endpackage

// File: rtl/cpu_8bit_alu.sv
// cpu_8bit_alu: combinational ALU for the accumulator CPU.
// Ports:
//   a, b    in  DATA_W  operands (A and B registers)
//   op      in  4       opcode (instr[7:4])
//   result  out DATA_W  A op B, mod 256; 0 for non-ALU opcodes
//   zero    out 1       result == 0
// Optional feature macro: CPU_8BIT_LOGIC_OPS_EN (AND/OR/XOR produce results;
// otherwise opcodes 6-8 give 0 like any non-ALU opcode).
module cpu_8bit_alu
  import cpu_8bit_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
`ifdef CPU_8BIT_LOGIC_OPS_EN
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
`endif
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/cpu_8bit.sv
// cpu_8bit: self-contained 8-bit accumulator CPU with a 16x8 unified
// program/data memory, registers A and B, a zero flag and a three-state
// (FETCH/DECODE/EXECUTE) sequencer plus an absorbing HALT state.
// Ports:
//   clk   in  1  rising-edge clock
//   rst   in  1  synchronous active-high reset (also reloads the program)
//   halt  out 1  high while in HALT
// Probe signals: instr, pc, state, a_reg_o, b_reg_o, mem_addr, mem_d_o,
// alu_res, zf.
// Optional feature macro: CPU_8BIT_LOGIC_OPS_EN (AND/OR/XOR instructions).
module cpu_8bit
  import cpu_8bit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic halt
);

  state_t              state;
  state_t              state_next;
  logic [DATA_W-1:0]   instr;
  logic [ADDR_W-1:0]   pc;
  logic [DATA_W-1:0]   a_reg_o;
  logic [DATA_W-1:0]   b_reg_o;
  logic                zf;
  logic [DATA_W-1:0]   mem [MEM_DEPTH];
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_d_o;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_zero;
  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   operand;

  assign opcode  = instr[7:4];
  assign operand = instr[3:0];

  cpu_8bit_alu u_alu (
    .a      (a_reg_o),
    .b      (b_reg_o),
    .op     (opcode),
    .result (alu_res),
    .zero   (alu_zero)
  );

  // Only FETCH addresses memory by pc; every other state uses the operand.
  assign mem_addr = (state == ST_FETCH) ? pc : operand;
  assign mem_d_o  = mem[mem_addr];
  assign halt     = (state == ST_HALT);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:   state_next = ST_DECODE;
      ST_DECODE:  state_next = ST_EXECUTE;
      ST_EXECUTE: state_next = (opcode == OP_HLT) ? ST_HALT : ST_FETCH;
      ST_HALT:    state_next = ST_HALT;
      default:    state_next = ST_FETCH;
    endcase
  end

  // Datapath: all architectural updates happen on the FETCH and EXECUTE
  // edges; DECODE and HALT leave everything untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      instr   <= '0;
      a_reg_o <= '0;
      b_reg_o <= '0;
      zf      <= 1'b0;
      mem     <= DEFAULT_PROG;
    end else begin
      case (state)
        ST_FETCH: begin
          instr <= mem_d_o;
          pc    <= pc + 1'b1;
        end
        ST_EXECUTE: begin
          if (is_alu_op(opcode)) begin
            a_reg_o <= alu_res;
            zf      <= alu_zero;
          end else begin
            case (opcode)
              OP_LDA: a_reg_o <= mem_d_o;
              OP_LDB: b_reg_o <= mem_d_o;
              OP_STA: mem[operand] <= a_reg_o;
              OP_JMP: pc <= operand;
              OP_JZ:  if (zf) pc <= operand;
              OP_LDI: a_reg_o <= {4'b0, operand};
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_8bit.sv
// tb_cpu_8bit: directed bench for cpu_8bit. Runs the built-in program from
// reset, checks architectural state at hand-computed cycle counts, checks the
// HALT behaviour, a mid-EXECUTE reset, and exercises the ALU standalone for
// wrap-around and logic-op cases (expected values depend on
// CPU_8BIT_LOGIC_OPS_EN).
module tb_cpu_8bit;
  import cpu_8bit_pkg::*;

  logic clk;
  logic rst;
  logic halt;

  int checks;
  int errors;

  logic [7:0] ta;
  logic [7:0] tb;
  logic [3:0] top;
  logic [7:0] tres;
  logic       tzero;

  cpu_8bit dut (
    .clk  (clk),
    .rst  (rst),
    .halt (halt)
  );

  cpu_8bit_alu u_alu_chk (
    .a      (ta),
    .b      (tb),
    .op     (top),
    .result (tres),
    .zero   (tzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    ta = '0; tb = '0; top = '0;

    // Reset state
    do_reset();
    check("rst_pc",    8'(dut.pc), 8'h00);
    check("rst_a",     dut.a_reg_o, 8'h00);
    check("rst_b",     dut.b_reg_o, 8'h00);
    check("rst_state", 8'(dut.state), 8'h00);
    check("rst_halt",  8'(halt), 8'h00);

    // Program run: edge k = k-th clock edge after reset release
    rst = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      case (k)
        1: begin
          check("fetch_instr", dut.instr, 8'h1E);
          check("fetch_pc",    8'(dut.pc), 8'h01);
          check("fetch_state", 8'(dut.state), 8'h01);
        end
        3:  check("lda_a", dut.a_reg_o, 8'h03);
        6:  check("ldb_b", dut.b_reg_o, 8'h05);
        7:  check("add_alu_res", dut.alu_res, 8'h08);
        9: begin
          check("add_a",  dut.a_reg_o, 8'h08);
          check("add_zf", 8'(dut.zf), 8'h00);
        end
        12: check("sta_mem13", dut.mem[13], 8'h08);
        15: check("lda15_a", dut.a_reg_o, 8'h05);
        18: begin
          check("sub_a",  dut.a_reg_o, 8'h00);
          check("sub_zf", 8'(dut.zf), 8'h01);
        end
        21: check("jz_pc", 8'(dut.pc), 8'h08);
        23: check("halt_early", 8'(halt), 8'h00);
        24: begin
          check("halt_rise",  8'(halt), 8'h01);
          check("hlt_instr",  dut.instr, 8'hF0);
          check("mem12_skip", dut.mem[12], 8'h00);
        end
        default: ;
      endcase
    end

    // Halted: nothing changes
    for (int k = 0; k < 6; k++) tick();
    check("halt_hold",  8'(halt), 8'h01);
    check("halt_a",     dut.a_reg_o, 8'h00);
    check("halt_b",     dut.b_reg_o, 8'h05);
    check("halt_mem13", dut.mem[13], 8'h08);
    check("halt_alu0",  dut.alu_res, 8'h00);

    // Reset while in EXECUTE (LDA 15 is executing after edge 14)
    do_reset();
    rst = 1'b0;
    for (int k = 1; k <= 14; k++) tick();
    check("pre_rst_state", 8'(dut.state), 8'h02);
    check("pre_rst_mem13", dut.mem[13], 8'h08);
    rst = 1'b1;
    tick();
    check("mid_rst_state", 8'(dut.state), 8'h00);
    check("mid_rst_pc",    8'(dut.pc), 8'h00);
    check("mid_rst_a",     dut.a_reg_o, 8'h00);
    check("mid_rst_mem13", dut.mem[13], 8'h00);
    check("mid_rst_halt",  8'(halt), 8'h00);
    rst = 1'b0;
    tick();

    // ALU corner cases
    ta = 8'h03; tb = 8'h05; top = 4'h5; #1;
    check("sub_wrap_res",  tres, 8'hFE);
    check("sub_wrap_zero", 8'(tzero), 8'h00);
    ta = 8'hFF; tb = 8'h01; top = 4'h4; #1;
    check("add_wrap_res",  tres, 8'h00);
    check("add_wrap_zero", 8'(tzero), 8'h01);
    ta = 8'h0F; tb = 8'hFF; top = 4'h8; #1;
`ifdef CPU_8BIT_LOGIC_OPS_EN
    check("xor_res", tres, 8'hF0);
`else
    check("xor_res", tres, 8'h00);
`endif
    ta = 8'hF3; tb = 8'h3C; top = 4'h6; #1;
`ifdef CPU_8BIT_LOGIC_OPS_EN
    check("and_res", tres, 8'h30);
`else
    check("and_res", tres, 8'h00);
`endif
    ta = 8'h12; tb = 8'h34; top = 4'h9; #1;
    check("jmp_alu0", tres, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
